// File: rtl/state_log_reader.sv
// Timestamped change log for a debug state bus: every change of iDbgSt is queued
// as {timestamp, state} in a small FIFO and popped one entry at a time by a reader.
module state_log_reader #(
    parameter int BITS    = 8,
    parameter int TS_BITS = 16,
    parameter int DEPTH   = 8
) (
    input  logic                       iClk,
    input  logic                       iRst_n,
    input  logic                       iClear,
    input  logic [BITS-1:0]            iDbgSt,
    input  logic                       iRdReq,
    output logic [TS_BITS+BITS-1:0]    oRdData,
    output logic                       oRdValid,
    output logic                       oEmpty,
    output logic                       oFull,
    output logic                       oOverflow,
    output logic [$clog2(DEPTH):0]     oCount
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = TS_BITS + BITS;

    logic [EW-1:0]      mem [DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [CW-1:0]      count_r;
    logic [CW-1:0]      count_nxt;
    logic               empty_r;
    logic               full_r;
    logic               overflow_r;
    logic [TS_BITS-1:0] ts;
    logic [BITS-1:0]    baseline;
    logic               armed;
    logic [EW-1:0]      rd_data_r;
    logic               rd_valid_r;

    logic change;
    logic pop;
    logic push;
    logic drop;

    // Read handshake: iRdReq is a one-cycle request; when the FIFO is not empty the
    // head entry appears on oRdData with oRdValid high for exactly the next cycle.
    // A request while empty is ignored and oRdData keeps its previous value.
    always_comb begin
        change    = armed && (iDbgSt != baseline);
        pop       = iRdReq && !empty_r;
        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        push      = change && (!full_r || pop);
        drop      = change && full_r && !pop;
        count_nxt = count_r;
        if (push && !pop) begin
            count_nxt = count_r + CW'(1);
        end else if (pop && !push) begin
            count_nxt = count_r - CW'(1);
        end
    end

    always_ff @(posedge iClk) begin
        if (push && !iClear) begin
            mem[wr_ptr] <= {ts, iDbgSt};
        end
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_r    <= '0;
            empty_r    <= 1'b1;
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
            ts         <= '0;
            baseline   <= '0;
            armed      <= 1'b0;
            rd_data_r  <= '0;
            rd_valid_r <= 1'b0;
        end else if (iClear) begin
            // Flush and re-baseline on the next edge; the last popped data is kept.
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_r    <= '0;
            empty_r    <= 1'b1;
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
            ts         <= '0;
            armed      <= 1'b0;
            rd_valid_r <= 1'b0;
        end else begin
            rd_valid_r <= pop;
            if (pop) begin
                rd_data_r <= mem[rd_ptr];
                rd_ptr    <= rd_ptr + AW'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            count_r <= count_nxt;
            empty_r <= (count_nxt == '0);
            full_r  <= (count_nxt == CW'(DEPTH));
            if (drop) begin
                overflow_r <= 1'b1;
            end
            if (!armed) begin
                armed    <= 1'b1;
                baseline <= iDbgSt;
            end else begin
                ts <= ts + TS_BITS'(1);
                // Baseline follows every change, including ones dropped on overflow.
                if (change) begin
                    baseline <= iDbgSt;
                end
            end
        end
    end

    assign oRdData   = rd_data_r;
    assign oRdValid  = rd_valid_r;
    assign oEmpty    = empty_r;
    assign oFull     = full_r;
    assign oOverflow = overflow_r;
    assign oCount    = count_r;

endmodule

// File: tb/tb_state_log_reader.sv
// Directed bench for state_log_reader: baseline, single change, overflow, full
// boundary, empty read, clear, async reset and timestamp wrap (TS_BITS=4 instance).
module tb_state_log_reader;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic [7:0]  dbg;
    logic        rd_req;
    logic [23:0] rd_data;
    logic        rd_valid;
    logic        empty;
    logic        full;
    logic        overflow;
    logic [3:0]  count;

    logic        w_clear;
    logic [7:0]  w_dbg;
    logic        w_rd_req;
    logic [11:0] w_rd_data;
    logic        w_rd_valid;
    logic        w_empty;
    logic        w_full;
    logic        w_overflow;
    logic [1:0]  w_count;

    int errors;
    int checks;

    logic [23:0] exp_q[$];
    logic [23:0] last_rd;
    logic [15:0] ts_m;
    logic        armed_m;

    state_log_reader #(.BITS(8), .TS_BITS(16), .DEPTH(8)) u_dut (
        .iClk      (clk),
        .iRst_n    (rst_n),
        .iClear    (clear),
        .iDbgSt    (dbg),
        .iRdReq    (rd_req),
        .oRdData   (rd_data),
        .oRdValid  (rd_valid),
        .oEmpty    (empty),
        .oFull     (full),
        .oOverflow (overflow),
        .oCount    (count)
    );

    state_log_reader #(.BITS(8), .TS_BITS(4), .DEPTH(2)) u_wrap (
        .iClk      (clk),
        .iRst_n    (rst_n),
        .iClear    (w_clear),
        .iDbgSt    (w_dbg),
        .iRdReq    (w_rd_req),
        .oRdData   (w_rd_data),
        .oRdValid  (w_rd_valid),
        .oEmpty    (w_empty),
        .oFull     (w_full),
        .oOverflow (w_overflow),
        .oCount    (w_count)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Timestamp model advanced with the same rules the block follows, then one edge.
    task automatic tick();
        if (!rst_n || clear) begin
            ts_m    = '0;
            armed_m = 1'b0;
        end else if (!armed_m) begin
            armed_m = 1'b1;
        end else begin
            ts_m = ts_m + 16'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic change_push(input logic [7:0] v);
        dbg = v;
        exp_q.push_back({ts_m, v});
        tick();
    endtask

    task automatic do_pop(input string tag, input logic [23:0] exp);
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check({tag, "_valid"}, {31'd0, rd_valid}, 32'd1);
        check({tag, "_data"}, {8'd0, rd_data}, {8'd0, exp});
        last_rd = exp;
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        ts_m     = '0;
        armed_m  = 1'b0;
        last_rd  = '0;
        rst_n    = 1'b0;
        clear    = 1'b0;
        dbg      = 8'h05;
        rd_req   = 1'b0;
        w_clear  = 1'b0;
        w_dbg    = 8'h00;
        w_rd_req = 1'b0;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_empty", {31'd0, empty}, 32'd1);
        check("rst_count", {28'd0, count}, 32'd0);
        check("rst_full", {31'd0, full}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_data", {8'd0, rd_data}, 32'd0);

        // Baseline: constant 05 for 20 cycles yields no entries
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            check("base_empty", {31'd0, empty}, 32'd1);
            check("base_count", {28'd0, count}, 32'd0);
        end

        // Single change at timestamp 16'h0010 after a re-baseline
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        repeat (16) tick();
        dbg = 8'h0A;
        tick();
        check("single_count", {28'd0, count}, 32'd1);
        check("single_empty", {31'd0, empty}, 32'd0);
        do_pop("single", 24'h00100A);
        check("single_empty_after", {31'd0, empty}, 32'd1);
        tick();
        check("single_valid_drop", {31'd0, rd_valid}, 32'd0);

        // Overflow: nine changes, eighth fills, ninth dropped
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                change_push(8'h11 + 8'(i));
            end else begin
                dbg = 8'h19;
                tick();
            end
        end
        check("ovf_full", {31'd0, full}, 32'd1);
        check("ovf_count", {28'd0, count}, 32'd8);
        check("ovf_flag", {31'd0, overflow}, 32'd1);
        for (int i = 0; i < 8; i++) begin
            do_pop("ovf_pop", exp_q.pop_front());
        end
        check("ovf_empty", {31'd0, empty}, 32'd1);
        tick();
        check("ovf_baseline", {28'd0, count}, 32'd0);

        // Full boundary: change and pop in the same cycle while full
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) begin
            change_push(8'h21 + 8'(i));
        end
        check("fb_full", {31'd0, full}, 32'd1);
        check("fb_ovf0", {31'd0, overflow}, 32'd0);
        dbg = 8'h29;
        exp_q.push_back({ts_m, 8'h29});
        do_pop("fb_simul", exp_q.pop_front());
        check("fb_count", {28'd0, count}, 32'd8);
        check("fb_ovf", {31'd0, overflow}, 32'd0);
        for (int i = 0; i < 8; i++) begin
            do_pop("fb_pop", exp_q.pop_front());
        end
        check("fb_empty", {31'd0, empty}, 32'd1);

        // Read while empty is ignored
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        check("er_valid", {31'd0, rd_valid}, 32'd0);
        check("er_data", {8'd0, rd_data}, {8'd0, last_rd});

        // Clear with 3 entries and overflow set, colliding with change and pop
        for (int i = 0; i < 9; i++) begin
            if (i < 8) begin
                change_push(8'h31 + 8'(i));
            end else begin
                dbg = 8'h39;
                tick();
            end
        end
        check("clr_ovf_pre", {31'd0, overflow}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            do_pop("clr_pre_pop", exp_q.pop_front());
        end
        check("clr_count_pre", {28'd0, count}, 32'd3);
        clear  = 1'b1;
        rd_req = 1'b1;
        dbg    = 8'h3A;
        tick();
        clear  = 1'b0;
        rd_req = 1'b0;
        exp_q.delete();
        check("clr_count", {28'd0, count}, 32'd0);
        check("clr_ovf", {31'd0, overflow}, 32'd0);
        check("clr_valid", {31'd0, rd_valid}, 32'd0);
        check("clr_empty", {31'd0, empty}, 32'd1);
        check("clr_data_kept", {8'd0, rd_data}, {8'd0, last_rd});
        tick();
        check("clr_rebase", {28'd0, count}, 32'd0);
        tick();
        check("clr_rebase2", {28'd0, count}, 32'd0);
        change_push(8'h3B);
        check("clr_post_count", {28'd0, count}, 32'd1);

        // Async reset mid-burst
        dbg = 8'h3C;
        exp_q.push_back({ts_m, 8'h3C});
        do_pop("burst_pop", exp_q.pop_front());
        check("burst_count", {28'd0, count}, 32'd1);
        rst_n = 1'b0;
        #1;
        ts_m    = '0;
        armed_m = 1'b0;
        exp_q.delete();
        check("arst_empty", {31'd0, empty}, 32'd1);
        check("arst_count", {28'd0, count}, 32'd0);
        check("arst_full", {31'd0, full}, 32'd0);
        check("arst_ovf", {31'd0, overflow}, 32'd0);
        check("arst_valid", {31'd0, rd_valid}, 32'd0);
        check("arst_data", {8'd0, rd_data}, 32'd0);

        // Timestamp wrap on the 4-bit instance: change after 17 increments -> 4'h1
        tick();
        rst_n = 1'b1;
        tick();
        repeat (17) tick();
        check("wrap_empty_pre", {31'd0, w_empty}, 32'd1);
        w_dbg = 8'h5A;
        tick();
        check("wrap_count", {30'd0, w_count}, 32'd1);
        w_rd_req = 1'b1;
        tick();
        w_rd_req = 1'b0;
        check("wrap_valid", {31'd0, w_rd_valid}, 32'd1);
        check("wrap_data", {20'd0, w_rd_data}, 32'h15A);
        check("wrap_main_count", {28'd0, count}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/state_log_reader.md
# state_log_reader

Drain side of the debug state logging path: it watches a state-machine debug bus, records every change of value as a timestamped entry in a small FIFO, and lets a management-side reader (BMC mailbox or register interface) pop those entries one at a time. It sits between a sequencer's debug-state output and the host-readable register file. It provides a full change history with a read handshake, rather than only the last two states.

## Interface
- BITS, 8: width of the monitored debug state.
- TS_BITS, 16: width of the free-running cycle timestamp.
- DEPTH, 8: FIFO entries; power of two, minimum 2.
- iClk  input  1  clock; all logic rises on posedge.
- iRst_n  input  1  reset; asynchronous, active-low.
- iClear  input  1  synchronous flush and re-baseline, active-high.
- iDbgSt  input  BITS  monitored debug state, synchronous to iClk.
- iRdReq  input  1  single-cycle pop request.
- oRdData  output  TS_BITS+BITS  popped entry, {timestamp, state}.
- oRdValid  output  1  one-cycle strobe that qualifies oRdData.
- oEmpty  output  1  FIFO holds no entries.
- oFull  output  1  FIFO holds DEPTH entries.
- oOverflow  output  1  sticky; at least one change was dropped.
- oCount  output  $clog2(DEPTH)+1  entries held, 0..DEPTH.

## Operation
- Reset values: oRdData=0, oRdValid=0, oEmpty=1, oFull=0, oOverflow=0, oCount=0. Internal state: timestamp=0, baseline register=0, armed=0, pointers=0.
- Baseline:
  - On the first posedge with armed=0, the block loads iDbgSt into the baseline register, sets armed=1 and generates no entry.
  - iClear also clears armed, so the baseline is re-taken on the cycle after the clear.
- Timestamp: increments by 1 on every posedge while armed. It wraps modulo 2^TS_BITS with no flag. It holds at 0 while unarmed.
- Change detect: a change event is armed=1 and iDbgSt != baseline.
  - On an event, the baseline register loads iDbgSt.
  - The block pushes the entry {timestamp before increment, iDbgSt}.
  - Consecutive differing values on back-to-back cycles each produce one entry.
- Full:
  - A change event while full with no pop in the same cycle drops the entry and sets oOverflow.
  - The baseline still updates on a dropped event.
- Pop:
  - iRdReq while not empty registers the head entry onto oRdData, pulses oRdValid for one cycle and advances the read pointer.
  - iRdReq while empty is ignored: oRdValid stays 0 and oRdData holds.
  - oRdData holds its last value between pops.
- Simultaneous push and pop:
  - When not empty, both are performed and oCount is unchanged.
  - When full, both are performed, nothing is dropped and oOverflow is not set.
  - When empty, the push is accepted and the pop is ignored. There is no bypass.
- iClear:
  - Flushes the pointers, sets oCount=0, clears oOverflow and the timestamp, and clears armed.
  - oRdValid=0 in the following cycle.
  - iClear has priority over a simultaneous push or pop.
  - oRdData is not cleared.
- Async reset asserted mid-operation returns every output to its reset value immediately. All entries are lost.

## Timing
- Change latency:
  - iDbgSt changes and is sampled at edge N.
  - The entry is counted in oCount, oEmpty and oFull after edge N.
  - The stored timestamp equals the counter value just before edge N.
- Read latency: iRdReq sampled at edge M -> oRdData/oRdValid valid after edge M, for one cycle.
- Sustained rate: one push and one pop per cycle.
- oEmpty, oFull and oCount are registered and consistent with each other every cycle.
- oOverflow asserts after the edge on which the drop occurs.

## Test plan
- Baseline:
  - Stimulus: release reset with iDbgSt=8'h05 held for 20 cycles.
  - Required: oEmpty=1 and oCount=0 throughout; no entry for the initial value.
- Single change:
  - Stimulus: after baseline, step iDbgSt 05->0A when the timestamp reads 16'h0010, then pulse iRdReq.
  - Required: one cycle later, oRdValid=1 and oRdData={16'h0010, 8'h0A}; afterwards oEmpty=1.
- Overflow (DEPTH=8):
  - Stimulus: 9 changes with no reads.
  - Required: oFull=1, oCount=8, oOverflow=1. Eight pops return the first eight states in order. The ninth value is present only as the baseline.
- Full boundary:
  - Stimulus: while full, a change coincides with iRdReq.
  - Required: oCount stays 8, oOverflow stays 0, and the new entry is popped last.
- Empty read and clear:
  - Empty read: iRdReq while empty leaves oRdValid=0 and oRdData unchanged.
  - Clear: with 3 entries and oOverflow=1, iClear together with a change and iRdReq gives oCount=0, oOverflow=0 and oRdValid=0. The following cycle re-baselines with no entry.
- Wrap and reset:
  - Wrap: with TS_BITS=4, place a change 17 cycles after arming; it records timestamp 4'h1.
  - Reset: asserting iRst_n low mid-burst immediately yields all reset values.
